key_debouncer: RTL and testbench
================================

// Module: key_debouncer
// PURPOSE
//  Conditions one raw push-button line before it reaches the 1-bit key PIO input port.
//  Processing chain: 2-flop synchronizer, then a 4-state debounce FSM, then outputs.
//  Outputs:
//   - key_out: clean, active-high level, wired to the PIO in_port.
//   - press_pulse / release_pulse: single-cycle strobes for local note-on/off logic.
//  Placed directly upstream of the key PIO in the synthesizer top level. One instance per key.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable sync samples required (20 ms @ 50 MHz); legal >= 2
//  ACTIVE_LOW       1        1: key_raw low = pressed (DE-board keys); 0: key_raw high = pressed
// PORTS
//  clk            in   1  system clock; all state on rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  key_raw        in   1  asynchronous button pin
//  key_out        out  1  debounced level, 1 = pressed
//  press_pulse    out  1  1-cycle strobe on debounced press
//  release_pulse  out  1  1-cycle strobe on debounced release
// BEHAVIOUR
//  Synchronizer and pressed flag
//   - s1 <= key_raw; s2 <= s1.
//   - Both reset to the released level: ACTIVE_LOW ? 1 : 0.
//   - pressed_s = ACTIVE_LOW ? ~s2 : s2.
//  Counter
//   - cnt is $clog2(DEBOUNCE_CYCLES) bits wide and resets to 0.
//   - It never wraps: maximum value is DEBOUNCE_CYCLES-1.
//  FSM states: RELEASED (reset state), PRESS_WAIT, PRESSED, RELEASE_WAIT
//   - RELEASED:     pressed_s=1 -> PRESS_WAIT, cnt<=0; else stay.
//   - PRESS_WAIT:   pressed_s=0 -> RELEASED (bounce abort, no pulse);
//                   cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press_pulse<=1;
//                   else cnt<=cnt+1.
//   - PRESSED:      pressed_s=0 -> RELEASE_WAIT, cnt<=0; else stay.
//   - RELEASE_WAIT: pressed_s=1 -> PRESSED (abort, no pulse);
//                   cnt==DEBOUNCE_CYCLES-1 -> RELEASED, release_pulse<=1;
//                   else cnt<=cnt+1.
//   - The abort check has priority over the terminal count in both WAIT states.
//  Outputs
//   - key_out is registered: 1 in PRESSED and RELEASE_WAIT, 0 in RELEASED and PRESS_WAIT.
//   - key_out changes on the same edge as the corresponding pulse.
//   - Each pulse is registered and high for exactly 1 cycle per accepted transition.
//   - press_pulse and release_pulse are never high together.
//  Latency
//   - With key_raw stable after a change, key_out/pulse update on clk edge DEBOUNCE_CYCLES+3.
//   - Breakdown: 2 synchronizer edges + 1 FSM-entry edge + DEBOUNCE_CYCLES count edges.
//  Glitches
//   - Any glitch shorter than DEBOUNCE_CYCLES sync samples never alters key_out.
//   - After an abort, the next qualifying edge restarts the count from 0.
//  Reset
//   - Reset values: key_out=0, press_pulse=0, release_pulse=0, state=RELEASED, cnt=0.
//   - Assertion mid-operation (any state, key held or not) forces these values immediately.
//   - After release of reset with the key held: a full press qualification starts
//     (DEBOUNCE_CYCLES+3 edges) and press_pulse fires once.
// TESTING (DEBOUNCE_CYCLES=8, ACTIVE_LOW=1)
//  1 Reset, key_raw=1 held 50 cycles -> key_out=0, no pulses throughout.
//  2 key_raw 1->0 held -> key_out=1 and press_pulse=1 on edge 11 after change;
//    press_pulse=0 on edge 12; key_out stays 1.
//  3 From PRESSED: key_raw 0->1 held -> release_pulse=1 on edge 11; key_out=0 on edge 11.
//  4 Bounce: key_raw=0 for 5 cycles, 1 for 2, 0 for 4, then 1 -> key_out never rises,
//    zero pulses; repeat while in PRESSED -> key_out never falls.
//  5 Press, bounce 0/1/0 at 1-cycle spacing, then 0 stable ->
//    exactly one press_pulse, 11 edges after the final 1->0.
//  6 Assert reset_n=0 in PRESS_WAIT (cnt=5) and in PRESSED -> outputs 0 asynchronously;
//    release reset with key_raw=0 -> press_pulse once, 11 edges later.

Source files
------------

// File: rtl/key_debouncer.sv
// Purpose: synchronizes and debounces one raw push-button line into a clean pressed level plus press/release strobes.
// Latency: a stable change on key_raw reaches key_out and its strobe on clk edge DEBOUNCE_CYCLES+3.
// Backpressure: none; the block samples every cycle and its strobes are single-cycle, so the consumer must always accept them.
//
// Ports:
//   clk           - system clock, all state on rising edge
//   reset_n       - asynchronous active-low reset
//   key_raw       - asynchronous button pin (polarity set by ACTIVE_LOW)
//   key_out       - debounced level, 1 = pressed
//   press_pulse   - one-cycle strobe when a press is accepted
//   release_pulse - one-cycle strobe when a release is accepted
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level when the button is not pressed; the synchronizer resets to it
    // so that coming out of reset never looks like a press edge.
    localparam logic              REL_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic             s1;
    logic             s2;
    logic             pressed_s;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= REL_LVL;
            s2 <= REL_LVL;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    assign pressed_s = ACTIVE_LOW ? ~s2 : s2;

    // Debounce FSM. A WAIT state must see DEBOUNCE_CYCLES consecutive samples
    // at the new level; any sample back at the old level aborts silently, and
    // that abort test is evaluated before the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RELEASED;
            cnt           <= '0;
            key_out       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (pressed_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_MAX) begin
                        state       <= PRESSED;
                        key_out     <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!pressed_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        state         <= RELEASED;
                        key_out       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= RELEASED;
                    cnt     <= '0;
                    key_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Purpose: directed self-checking bench for key_debouncer with DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.
// Latency: expects key_out and strobes on the 11th clock edge after a stable key_raw change.
// Backpressure: not applicable; the bench observes every cycle.
module tb_key_debouncer;

    logic clk = 1'b0;
    logic reset_n;
    logic key_raw;
    logic key_out;
    logic press_pulse;
    logic release_pulse;

    int vectors = 0;
    int errors  = 0;

    // Per-scenario observations, accumulated one clock edge at a time.
    int edge_no;
    int n_press;
    int n_release;
    int n_both;
    int n_key_hi;
    int n_key_lo;
    int last_press_edge;
    int last_release_edge;

    key_debouncer #(
        .DEBOUNCE_CYCLES(8),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_raw      (key_raw),
        .key_out      (key_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic clear_obs();
        edge_no           = 0;
        n_press           = 0;
        n_release         = 0;
        n_both            = 0;
        n_key_hi          = 0;
        n_key_lo          = 0;
        last_press_edge   = -1;
        last_release_edge = -1;
    endtask

    // Advance n rising edges; outputs are sampled 1 ns after each edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (press_pulse === 1'b1) begin
                n_press++;
                last_press_edge = edge_no;
            end
            if (release_pulse === 1'b1) begin
                n_release++;
                last_release_edge = edge_no;
            end
            if (press_pulse === 1'b1 && release_pulse === 1'b1) n_both++;
            if (key_out === 1'b1) n_key_hi++;
            else                  n_key_lo++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_raw = 1'b1;
        #23;
        vectors++;
        if (key_out !== 1'b0) begin
            errors++; $display("FAIL reset_key_out got=%b exp=0", key_out);
        end
        vectors++;
        if (press_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_press_pulse got=%b exp=0", press_pulse);
        end
        vectors++;
        if (release_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_release_pulse got=%b exp=0", release_pulse);
        end
        reset_n = 1'b1;
        clear_obs();
        tick(50);
        vectors++;
        if (n_key_hi !== 0) begin
            errors++; $display("FAIL idle_key_out_high_cycles got=%0d exp=0", n_key_hi);
        end
        vectors++;
        if (n_press + n_release !== 0) begin
            errors++; $display("FAIL idle_pulses got=%0d exp=0", n_press + n_release);
        end
    endtask

    task automatic test_press();
        clear_obs();
        key_raw = 1'b0;
        tick(10);
        vectors++;
        if (key_out !== 1'b0 || n_press !== 0) begin
            errors++; $display("FAIL press_early key_out=%b pulses=%0d exp key_out=0 pulses=0", key_out, n_press);
        end
        tick(1);
        vectors++;
        if (key_out !== 1'b1 || press_pulse !== 1'b1) begin
            errors++; $display("FAIL press_edge11 key_out=%b press_pulse=%b exp 1 1", key_out, press_pulse);
        end
        tick(1);
        vectors++;
        if (press_pulse !== 1'b0 || key_out !== 1'b1) begin
            errors++; $display("FAIL press_edge12 press_pulse=%b key_out=%b exp 0 1", press_pulse, key_out);
        end
        tick(20);
        vectors++;
        if (n_press !== 1 || last_press_edge !== 11 || n_release !== 0) begin
            errors++; $display("FAIL press_count press=%0d at_edge=%0d release=%0d exp 1 11 0", n_press, last_press_edge, n_release);
        end
    endtask

    task automatic test_release();
        clear_obs();
        key_raw = 1'b1;
        tick(10);
        vectors++;
        if (key_out !== 1'b1 || n_release !== 0) begin
            errors++; $display("FAIL release_early key_out=%b pulses=%0d exp key_out=1 pulses=0", key_out, n_release);
        end
        tick(1);
        vectors++;
        if (release_pulse !== 1'b1 || key_out !== 1'b0) begin
            errors++; $display("FAIL release_edge11 release_pulse=%b key_out=%b exp 1 0", release_pulse, key_out);
        end
        tick(1);
        vectors++;
        if (release_pulse !== 1'b0) begin
            errors++; $display("FAIL release_edge12 release_pulse=%b exp 0", release_pulse);
        end
        tick(20);
        vectors++;
        if (n_release !== 1 || n_press !== 0 || n_both !== 0) begin
            errors++; $display("FAIL release_count release=%0d press=%0d both=%0d exp 1 0 0", n_release, n_press, n_both);
        end
    endtask

    task automatic test_bounce();
        // Bounce while released: 0x5, 1x2, 0x4, then 1.
        clear_obs();
        key_raw = 1'b0; tick(5);
        key_raw = 1'b1; tick(2);
        key_raw = 1'b0; tick(4);
        key_raw = 1'b1; tick(20);
        vectors++;
        if (n_key_hi !== 0 || n_press + n_release !== 0) begin
            errors++; $display("FAIL bounce_released key_hi_cycles=%0d pulses=%0d exp 0 0", n_key_hi, n_press + n_release);
        end
        // Enter PRESSED, then the mirrored bounce pattern.
        key_raw = 1'b0; tick(20);
        vectors++;
        if (key_out !== 1'b1) begin
            errors++; $display("FAIL bounce_setup_press key_out=%b exp 1", key_out);
        end
        clear_obs();
        key_raw = 1'b1; tick(5);
        key_raw = 1'b0; tick(2);
        key_raw = 1'b1; tick(4);
        key_raw = 1'b0; tick(20);
        vectors++;
        if (n_key_lo !== 0 || n_press + n_release !== 0) begin
            errors++; $display("FAIL bounce_pressed key_lo_cycles=%0d pulses=%0d exp 0 0", n_key_lo, n_press + n_release);
        end
        clear_obs();
        key_raw = 1'b1; tick(20);
        vectors++;
        if (n_release !== 1 || key_out !== 1'b0) begin
            errors++; $display("FAIL bounce_final_release release=%0d key_out=%b exp 1 0", n_release, key_out);
        end
    endtask

    task automatic test_press_bounce();
        key_raw = 1'b0; tick(1);
        key_raw = 1'b1; tick(1);
        clear_obs();
        key_raw = 1'b0; tick(25);
        vectors++;
        if (n_press !== 1 || last_press_edge !== 11) begin
            errors++; $display("FAIL press_bounce press=%0d at_edge=%0d exp 1 11", n_press, last_press_edge);
        end
        key_raw = 1'b1; tick(20);
        vectors++;
        if (key_out !== 1'b0) begin
            errors++; $display("FAIL press_bounce_restore key_out=%b exp 0", key_out);
        end
    endtask

    task automatic test_reset_mid();
        // Reset in PRESS_WAIT with cnt=5 (edge 3 enters, edges 4..8 count to 5).
        clear_obs();
        key_raw = 1'b0;
        tick(8);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (key_out !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_in_wait outs=%b%b%b exp 000", key_out, press_pulse, release_pulse);
        end
        tick(3);
        vectors++;
        if (key_out !== 1'b0 || n_press !== 0) begin
            errors++; $display("FAIL reset_held key_out=%b press=%0d exp 0 0", key_out, n_press);
        end
        // Release reset with key held: full qualification from scratch.
        clear_obs();
        reset_n = 1'b1;
        tick(10);
        vectors++;
        if (n_press !== 0 || key_out !== 1'b0) begin
            errors++; $display("FAIL reset_rel_early press=%0d key_out=%b exp 0 0", n_press, key_out);
        end
        tick(1);
        vectors++;
        if (press_pulse !== 1'b1 || key_out !== 1'b1) begin
            errors++; $display("FAIL reset_rel_edge11 press_pulse=%b key_out=%b exp 1 1", press_pulse, key_out);
        end
        tick(5);
        // Reset in PRESSED, between clock edges.
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (key_out !== 1'b0) begin
            errors++; $display("FAIL reset_in_pressed key_out=%b exp 0", key_out);
        end
        #2;
        clear_obs();
        reset_n = 1'b1;
        tick(30);
        vectors++;
        if (n_press !== 1 || last_press_edge !== 11 || key_out !== 1'b1) begin
            errors++; $display("FAIL reset_pressed_requal press=%0d at_edge=%0d key_out=%b exp 1 11 1", n_press, last_press_edge, key_out);
        end
        vectors++;
        if (n_both !== 0 || n_release !== 0) begin
            errors++; $display("FAIL reset_pressed_extra both=%0d release=%0d exp 0 0", n_both, n_release);
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_press_bounce();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
